regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- General-purpose register file with a per-register write-reservation scoreboard.
- It is the responder side of the decode-stage register interface:
  - Decode presents rd/rs names and gets back data plus reserved flags.
  - Decode reserves its destination register.
  - Writeback returns results and releases reservations.
- It sits between the ID stage (read/reserve port) and the WB stage (write port).

Parameters:
- WORD, 32, data width of one register.
- W_RD, 4, register-name width; NREG = 2**W_RD registers.
- W_CNT, 2, width of the per-register pending-write counter; CNT_MAX = 2**W_CNT - 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- rd_name_i  in  W_RD  ID destination-register name (read + reserve target).
- rs_name_i  in  W_RD  ID source-register name.
- rd_data_o  out  WORD  contents of rd_name_i (combinational, with WB bypass).
- rs_data_o  out  WORD  contents of rs_name_i (combinational, with WB bypass).
- rd_reserved_o  out  1  rd_name_i has a pending write.
- rs_reserved_o  out  1  rs_name_i has a pending write.
- rd_reserve_i  in  1  ID issues an instruction that will write rd_name_i; take a reservation.
- reserve_full_o  out  1  counter of rd_name_i is at CNT_MAX; a reservation would be refused.
- wb_v_i  in  1  WB write valid.
- wb_name_i  in  W_RD  WB destination name.
- wb_data_i  in  WORD  WB result.
- wb_err_o  out  1  sticky: writeback arrived for a register with zero pending count.

Behaviour:
- Storage: NREG x WORD data array plus NREG x W_CNT pending counters. All registers are general-purpose; no hardwired zero.
- Reset (rst==0 at clk edge):
  - all data words, counters and wb_err_o go to 0;
  - the combinational outputs follow, so data_o=0, reserved_o=0, reserve_full_o=0.
  - Reset mid-operation discards every outstanding reservation; a later wb_v_i to such a register is a zero-count writeback (sets wb_err_o).
- Read, zero latency, combinational:
  - x_data_o = wb_data_i if (wb_v_i && wb_name_i==x_name), else mem[x_name].
  - x_reserved_o = eff_cnt(x) != 0, where eff_cnt(x) = cnt[x] - (wb_v_i && wb_name_i==x ? 1 : 0), floored at 0.
  - Result: a register whose last pending write retires this cycle reads as unreserved, with the bypassed value.
- reserve_full_o = (cnt[rd_name_i] == CNT_MAX). This uses the raw count, not the bypassed one, so it stays combinationally independent of WB.
- Reservation accepted iff rd_reserve_i && !reserve_full_o. A refused reservation leaves state unchanged; ID must stall (ID folds reserve_full_o into its stall).
- Writeback, on the clock edge when wb_v_i:
  - mem[wb_name_i] <= wb_data_i;
  - if cnt[wb_name_i] != 0, decrement it;
  - else leave the counter at 0 and set wb_err_o (stays 1 until reset).
- Counter update per register r, with inc = accepted reserve to r and dec = wb_v_i to r with cnt[r] != 0:
  - inc && dec: unchanged.
  - inc only: +1.
  - dec only: -1.
  - Never wraps: full blocks inc, zero blocks dec.
- Same-cycle reserve and WB to the same register at CNT_MAX: the reserve is refused (raw-count rule) even though WB frees a slot. This is deliberately conservative.
- rd_name_i == rs_name_i: both ports return identical data and flags.
- Write ordering: WB results are assumed in program order per register; the data array keeps the last write.

Decomposition:
- WORD and W_RD come from the shared parameter include (include/params.vh), along with a new W_CNT constant.
- One natural sub-module, rf_pending_ctr: a W_CNT saturating up/down counter with inputs inc, dec, clear and outputs cnt, nonzero, full. It is instantiated NREG times via generate.
- The data array, read muxes, bypass and error flag stay in regfile_sb.

Test Plan:
- Reset then read: rst low 1 cycle; rs_name_i=3 -> rs_data_o=0, rs_reserved_o=0, wb_err_o=0.
- Reserve/writeback round trip: reserve r5; next cycle rd_name_i=5 -> rd_reserved_o=1. WB r5 with 0xDEADBEEF:
  - same cycle: rd_reserved_o=0 and rd_data_o=0xDEADBEEF (bypass);
  - after the edge: cnt[5]=0 and mem[5]=0xDEADBEEF.
- Saturation:
  - 3 back-to-back reserves of r2 -> reserve_full_o=1.
  - A 4th reserve is refused; cnt stays 3.
  - 3 WBs then bring rs_reserved_o (rs_name_i=2) to 0 only after the third.
- Simultaneous reserve and WB to r7 with cnt=1 -> cnt stays 1, mem[7] updated, rd_reserved_o stays 1 next cycle.
- Spurious writeback to r9 with cnt=0 -> mem[9] written, wb_err_o=1 and still 1 ten cycles later; rst low clears it.
- Reset mid-operation: reserve r1 and r4, assert rst, then WB r1 -> cnt[1]=0, wb_err_o=1, r4 unreserved.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared widths and types for the register file with write-reservation scoreboard.
package regfile_sb_pkg;

  localparam int WORD  = 32;
  localparam int W_RD  = 4;
  localparam int W_CNT = 2;
  localparam int NREG  = 2 ** W_RD;

  typedef logic [WORD-1:0]  word_t;
  typedef logic [W_RD-1:0]  name_t;
  typedef logic [W_CNT-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/regfile_sb_ctr.sv
// Saturating pending-write counter for one register: full blocks inc, zero blocks dec.
module rf_pending_ctr
  import regfile_sb_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic nonzero,
  output logic full
);

  logic do_inc;
  logic do_dec;

  assign full    = (cnt == CNT_MAX);
  assign nonzero = (cnt != '0);
  assign do_inc  = inc && !full;
  assign do_dec  = dec && nonzero;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + cnt_t'(1);
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - cnt_t'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write counters, WB bypass on reads and a sticky
// error flag for writebacks that arrive with nothing pending.
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  name_t rd_name_i,
  input  name_t rs_name_i,
  output word_t rd_data_o,
  output word_t rs_data_o,
  output logic  rd_reserved_o,
  output logic  rs_reserved_o,
  input  logic  rd_reserve_i,
  output logic  reserve_full_o,
  input  logic  wb_v_i,
  input  name_t wb_name_i,
  input  word_t wb_data_i,
  output logic  wb_err_o
);

  word_t mem     [NREG];
  cnt_t  cnt     [NREG];
  logic  nonzero [NREG];
  logic  full    [NREG];
  logic  hit_rd;
  logic  hit_rs;

  for (genvar r = 0; r < NREG; r++) begin : g_ctr
    rf_pending_ctr u_ctr (
      .clk     (clk),
      .clear   (!rst),
      .inc     (rd_reserve_i && !reserve_full_o && (rd_name_i == name_t'(r))),
      .dec     (wb_v_i && (wb_name_i == name_t'(r))),
      .cnt     (cnt[r]),
      .nonzero (nonzero[r]),
      .full    (full[r])
    );
  end

  // Raw count only, so the refuse decision never depends on the WB port.
  assign reserve_full_o = full[rd_name_i];

  assign hit_rd = wb_v_i && (wb_name_i == rd_name_i);
  assign hit_rs = wb_v_i && (wb_name_i == rs_name_i);

  assign rd_data_o = hit_rd ? wb_data_i : mem[rd_name_i];
  assign rs_data_o = hit_rs ? wb_data_i : mem[rs_name_i];

  // Count minus this cycle's retiring write, floored at zero, is nonzero exactly when cnt > hit.
  assign rd_reserved_o = (cnt[rd_name_i] > cnt_t'(hit_rd));
  assign rs_reserved_o = (cnt[rs_name_i] > cnt_t'(hit_rs));

  // NOTE: the data array is reset word by word because reads must return 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_v_i) begin
      mem[wb_name_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_err_o <= 1'b0;
    end else if (wb_v_i && !nonzero[wb_name_i]) begin
      wb_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_name_i, rs_name_i, wb_name_i;
  logic [31:0] rd_data_o, rs_data_o, wb_data_i;
  logic        rd_reserved_o, rs_reserved_o, rd_reserve_i, reserve_full_o, wb_v_i, wb_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_cnt [16];
  logic [31:0] m_mem [16];
  bit          m_err;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk            (clk),
    .rst            (rst),
    .rd_name_i      (rd_name_i),
    .rs_name_i      (rs_name_i),
    .rd_data_o      (rd_data_o),
    .rs_data_o      (rs_data_o),
    .rd_reserved_o  (rd_reserved_o),
    .rs_reserved_o  (rs_reserved_o),
    .rd_reserve_i   (rd_reserve_i),
    .reserve_full_o (reserve_full_o),
    .wb_v_i         (wb_v_i),
    .wb_name_i      (wb_name_i),
    .wb_data_i      (wb_data_i),
    .wb_err_o       (wb_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_reserved(input logic [3:0] n);
    int e;
    e = m_cnt[n] - ((wb_v_i && wb_name_i == n) ? 1 : 0);
    if (e < 0) e = 0;
    return e != 0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] n);
    return (wb_v_i && wb_name_i == n) ? wb_data_i : m_mem[n];
  endfunction

  // Compare outputs mid-cycle, then apply the clock edge to the model.
  task automatic cycle(input bit chk);
    bit acc;
    #1;
    if (chk) begin
      check("rd_data",      rd_data_o,      exp_data(rd_name_i));
      check("rs_data",      rs_data_o,      exp_data(rs_name_i));
      check("rd_reserved",  rd_reserved_o,  exp_reserved(rd_name_i));
      check("rs_reserved",  rs_reserved_o,  exp_reserved(rs_name_i));
      check("reserve_full", reserve_full_o, m_cnt[rd_name_i] == 3);
      check("wb_err",       wb_err_o,       m_err);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_cnt[i] = 0;
        m_mem[i] = '0;
      end
      m_err = 1'b0;
    end else begin
      acc = rd_reserve_i && (m_cnt[rd_name_i] < 3);
      if (wb_v_i) begin
        m_mem[wb_name_i] = wb_data_i;
        if (m_cnt[wb_name_i] == 0) m_err = 1'b1;
        else m_cnt[wb_name_i]--;
      end
      if (acc) m_cnt[rd_name_i]++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input logic [3:0] rdn, input logic [3:0] rsn, input bit res,
                       input bit wv, input logic [3:0] wn, input logic [31:0] wd);
    rst          = r;
    rd_name_i    = rdn;
    rs_name_i    = rsn;
    rd_reserve_i = res;
    wb_v_i       = wv;
    wb_name_i    = wn;
    wb_data_i    = wd;
    cycle(1'b1);
  endtask

  initial begin
    rst = 1'b0; rd_name_i = '0; rs_name_i = '0; rd_reserve_i = 1'b0;
    wb_v_i = 1'b0; wb_name_i = '0; wb_data_i = '0;
    cycle(1'b0);

    // Reset then read
    drive(1, 0, 3, 0, 0, 0, 0);

    // Reserve/writeback round trip on r5 with bypass
    drive(1, 5, 0, 1, 0, 0, 0);
    drive(1, 5, 5, 0, 0, 0, 0);
    drive(1, 5, 5, 0, 1, 5, 32'hDEAD_BEEF);
    drive(1, 5, 5, 0, 0, 0, 0);

    // Saturation on r2: four reserves, the last refused, then three WBs
    repeat (4) drive(1, 2, 2, 1, 0, 0, 0);
    drive(1, 2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2, 2, 0, 1, 2, 32'h2000_0000 + i);
    drive(1, 2, 2, 0, 0, 0, 0);

    // Full counter with same-cycle WB still refuses the reserve
    repeat (3) drive(1, 6, 6, 1, 0, 0, 0);
    drive(1, 6, 6, 1, 1, 6, 32'h6666_6666);
    drive(1, 6, 6, 0, 0, 0, 0);

    // Simultaneous reserve and WB on r7 with cnt=1
    drive(1, 7, 7, 1, 0, 0, 0);
    drive(1, 7, 7, 1, 1, 7, 32'h7777_0007);
    drive(1, 7, 7, 0, 0, 0, 0);

    // Spurious writeback to r9, sticky error, cleared by reset
    drive(1, 9, 9, 0, 1, 9, 32'h9999_0009);
    repeat (10) drive(1, 9, 9, 0, 0, 0, 0);
    drive(0, 9, 9, 0, 0, 0, 0);
    drive(1, 9, 9, 0, 0, 0, 0);

    // Reset mid-operation discards reservations
    drive(1, 1, 4, 1, 0, 0, 0);
    drive(1, 4, 1, 1, 0, 0, 0);
    drive(0, 4, 1, 0, 0, 0, 0);
    drive(1, 4, 1, 0, 1, 1, 32'h1111_0001);
    drive(1, 4, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 127) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
